fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with branch redirect.
// Optional perf counters (fetch_count/flush_count) under macro FETCH_PERF_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_plus_one,
    output logic [15:0] pc_data,
    output logic        pc_write,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] fetch_addr_q, fetch_addr_d;
    logic [15:0] kill_addr_q, kill_addr_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        pc_write_c;
    logic [15:0] pc_data_c;
    logic        xfer;

    assign xfer = valid_q & ~stall;

    // Next-state, fetch datapath and PC-load strobe; a branch overrides all.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        kill_addr_d  = kill_addr_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q;
        pc_write_c   = 1'b0;
        pc_data_c    = 16'h0000;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    instr_d      = mem_rdata;
                    instr_pc_d   = fetch_addr_q;
                    valid_d      = 1'b1;
                    pc_write_c   = 1'b1;
                    pc_data_c    = pc_plus_one;
                    fetch_addr_d = pc_plus_one;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            KILL: begin
                if (mem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        if (branch_valid) begin
            pc_write_c   = 1'b1;
            pc_data_c    = branch_target;
            fetch_addr_d = branch_target;
            instr_d      = instr_q;
            instr_pc_d   = instr_pc_q;
            valid_d      = 1'b0;
            if (state_q == FETCH && !mem_ack) begin
                kill_addr_d = fetch_addr_q;
                state_d     = KILL;
            end else if (state_q == KILL && !mem_ack) begin
                state_d = KILL;
            end else begin
                state_d = FETCH;
            end
        end
    end

    // State and fetch registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= 16'h0000;
            kill_addr_q  <= 16'h0000;
            instr_q      <= 16'h0000;
            instr_pc_q   <= 16'h0000;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            kill_addr_q  <= kill_addr_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
        end
    end

    // PC strobe is gated so it reads 0 while reset is held.
    assign pc_write    = pc_write_c & rst;
    assign pc_data     = rst ? pc_data_c : 16'h0000;
    assign mem_req     = (state_q == FETCH) || (state_q == KILL);
    assign mem_addr    = (state_q == KILL)  ? kill_addr_q :
                         (state_q == FETCH) ? fetch_addr_q : 16'h0000;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, flush_cnt_q;

    // Transfer and redirect counters, both wrapping modulo 2^16.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (xfer) begin
                fetch_cnt_q <= fetch_cnt_q + 16'h0001;
            end
            if (branch_valid) begin
                flush_cnt_q <= flush_cnt_q + 16'h0001;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule
